// File: rtl/uart_rx_oversampler.sv
// UART receiver with start-bit detection, mid-bit sampling from the 16x rx_enb tick and a valid/ready byte output.
// Define UART_RX_PARITY_EN to insert a parity bit after the data bits; PARITY_ODD selects its sense.
module uart_rx_oversampler #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enb,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_oversampler: DATA_BITS must be in 5..8");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_oversampler: OVERSAMPLE must be even and >= 4");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx_oversampler: PARITY_ODD must be 0 or 1");
  end

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK_WAIT
  } state_t;
`endif

  state_t                 state;
  logic                   rx_meta;
  logic                   rxs;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   deliver;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bad;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  // NOTE: sequential state uses nonblocking updates only; the error/deliver pulses are
  // defaulted low at the top of the clocked branch so each one lasts exactly one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      deliver    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      deliver   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_enb) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end

          START: begin
            if (tick_cnt == TICK_MID) begin
              if (rxs) begin
                state <= IDLE;
              end else begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          DATA: begin
            if (tick_cnt == TICK_END) begin
              // Line order is LSB first, so bits enter at the top and walk down.
              shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
              tick_cnt  <= '0;
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == TICK_END) begin
              parity_bad <= rxs ^ (^shift_reg) ^ PAR_ODD;
              tick_cnt   <= '0;
              state      <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif

          STOP: begin
            if (tick_cnt == TICK_END) begin
              tick_cnt <= '0;
              if (!rxs) begin
                frame_err <= 1'b1;
                state     <= BRK_WAIT;
              end else begin
                state <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (parity_bad) begin
                  parity_err <= 1'b1;
                end else begin
                  deliver <= 1'b1;
                end
`else
                deliver <= 1'b1;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          // A held-low line (break) must return high before a new start can be detected.
          BRK_WAIT: begin
            if (rxs) begin
              state <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Output holding register: a delivery wins over an accept in the same cycle, and a
  // delivery into an unread, unaccepted byte is dropped with an overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler: rx_enb every 4 clk, 64 clk per bit on rx_in.
// Framed byte vectors run from a table; break, glitch, overrun, reset and parity cases are hand-written.
module tb_uart_rx_oversampler;

  localparam int CLK_PER_BIT = 64;

  logic       clk;
  logic       rst;
  logic       rx_enb;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  uart_rx_oversampler #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .PARITY_ODD (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_enb     (rx_enb),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rx_enb = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      rx_enb = 1'b1;
      @(negedge clk);
      rx_enb = 1'b0;
    end
  end

  // Event monitor: pulse counts are in clk cycles high, so a 1-clk pulse adds exactly 1.
  int         n_checks     = 0;
  int         n_errors     = 0;
  int         valid_rise   = 0;
  int         valid_cycles = 0;
  int         ferr_cnt     = 0;
  int         ovr_cnt      = 0;
  int         perr_cnt     = 0;
  logic       valid_q      = 1'b0;
  logic [7:0] last_data    = 8'h00;

  always @(negedge clk) begin
    if (frame_err)  ferr_cnt++;
    if (overrun)    ovr_cnt++;
    if (parity_err) perr_cnt++;
    if (rx_valid)   valid_cycles++;
    if (rx_valid && !valid_q) begin
      valid_rise++;
      last_data = rx_data;
    end
    valid_q = rx_valid;
  end

  int b_rise, b_vcyc, b_ferr, b_ovr, b_perr;

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    b_rise = valid_rise;
    b_vcyc = valid_cycles;
    b_ferr = ferr_cnt;
    b_ovr  = ovr_cnt;
    b_perr = perr_cnt;
  endtask

  task automatic bits(input int n);
    repeat (n * CLK_PER_BIT) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level; callers return it high with idle().
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_in = 1'b0;
    bits(1);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rx_in = (^d) ^ par_flip;
    bits(1);
`endif
    rx_in = stop;
    bits(1);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    bits(n);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1, exp_data: 'hA5, exp_ferr: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1, exp_data: 'h00, exp_ferr: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_data: 'hFF, exp_ferr: 0};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_valid: 0, exp_data: 'h00, exp_ferr: 1};
    vecs[4] = '{data: 8'hC3, stop: 1'b1, exp_valid: 1, exp_data: 'hC3, exp_ferr: 0};

    rst      = 1'b1;
    rx_in    = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("reset rx_valid",   int'(rx_valid),   0);
    check("reset rx_data",    int'(rx_data),    0);
    check("reset frame_err",  int'(frame_err),  0);
    check("reset overrun",    int'(overrun),    0);
    check("reset parity_err", int'(parity_err), 0);
    check("reset busy",       int'(busy),       0);
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 5; i++) begin
      snap();
      send_frame(vecs[i].data, vecs[i].stop);
      idle(2);
      check($sformatf("vec%0d valid_rise", i), valid_rise - b_rise, vecs[i].exp_valid);
      if (vecs[i].exp_valid != 0) begin
        check($sformatf("vec%0d rx_data", i), int'(last_data), vecs[i].exp_data);
        check($sformatf("vec%0d valid_width", i), valid_cycles - b_vcyc, 1);
      end
      check($sformatf("vec%0d frame_err", i),  ferr_cnt - b_ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d overrun", i),    ovr_cnt - b_ovr, 0);
      check($sformatf("vec%0d parity_err", i), perr_cnt - b_perr, 0);
      check($sformatf("vec%0d busy_after", i), int'(busy), 0);
    end

    // Short low glitch (5 ticks): START is entered, then abandoned at the mid-start sample.
    snap();
    rx_in = 1'b0;
    repeat (20) @(negedge clk);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("glitch busy_during", int'(busy), 1);
    idle(2);
    check("glitch busy_after", int'(busy), 0);
    check("glitch valid_rise", valid_rise - b_rise, 0);
    check("glitch frame_err",  ferr_cnt - b_ferr, 0);

    // Bad stop bit followed by a 40-bit-time break: exactly one frame_err.
    snap();
    send_frame(8'h3C, 1'b0);
    rx_in = 1'b0;
    bits(39);
    check("break busy_held",  int'(busy), 1);
    check("break frame_err",  ferr_cnt - b_ferr, 1);
    check("break valid_rise", valid_rise - b_rise, 0);
    idle(2);
    check("break busy_after", int'(busy), 0);
    snap();
    send_frame(8'h55, 1'b1);
    idle(2);
    check("post_break valid_rise", valid_rise - b_rise, 1);
    check("post_break rx_data",    int'(last_data), 'h55);
    check("post_break frame_err",  ferr_cnt - b_ferr, 0);

    // Consumer stalled: second byte overruns, first byte stays put.
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    idle(2);
    send_frame(8'h22, 1'b1);
    idle(2);
    check("ovr valid_rise", valid_rise - b_rise, 1);
    check("ovr rx_valid",   int'(rx_valid), 1);
    check("ovr rx_data",    int'(rx_data), 'h11);
    check("ovr pulse",      ovr_cnt - b_ovr, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr accept rx_valid", int'(rx_valid), 0);
    @(negedge clk);
    rx_ready = 1'b0;

    // Park a byte in the output, then reset in the middle of data bit 4 of 0xFF.
    send_frame(8'h5A, 1'b1);
    idle(2);
    check("pre_rst rx_valid", int'(rx_valid), 1);
    check("pre_rst rx_data",  int'(rx_data), 'h5A);
    rx_in = 1'b0;
    bits(1);
    rx_in = 1'b1;
    bits(4);
    repeat (CLK_PER_BIT / 2) @(negedge clk);
    check("pre_rst busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst rx_valid",  int'(rx_valid),  0);
    check("mid_rst rx_data",   int'(rx_data),   0);
    check("mid_rst busy",      int'(busy),      0);
    check("mid_rst frame_err", int'(frame_err), 0);
    check("mid_rst overrun",   int'(overrun),   0);
    rst = 1'b0;
    rx_ready = 1'b1;
    idle(6);
    check("post_rst busy", int'(busy), 0);
    snap();
    send_frame(8'h81, 1'b1);
    idle(2);
    check("post_rst valid_rise", valid_rise - b_rise, 1);
    check("post_rst rx_data",    int'(last_data), 'h81);
    check("post_rst frame_err",  ferr_cnt - b_ferr, 0);
    check("post_rst overrun",    ovr_cnt - b_ovr, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    snap();
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    idle(2);
    check("par_ok valid_rise", valid_rise - b_rise, 1);
    check("par_ok rx_data",    int'(last_data), 'h07);
    check("par_ok parity_err", perr_cnt - b_perr, 0);
    snap();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    idle(2);
    par_flip = 1'b0;
    check("par_bad valid_rise", valid_rise - b_rise, 0);
    check("par_bad parity_err", perr_cnt - b_perr, 1);
    check("par_bad frame_err",  ferr_cnt - b_ferr, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
